// File: rtl/stream_window_avg.sv
// Sliding-window moving average over the last DEPTH unsigned samples.
// The running sum is divided by DEPTH with a serial restoring divider, one quotient bit per cycle.
module stream_window_avg #(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 6,
    parameter  int LEGACY_OVF = 1,
    localparam int ACC_W      = WIDTH + $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] avg,
    output logic             overflow,
    output logic [CNT_W-1:0] fill_count,
    output logic [1:0]       dbg_state
);
    // Handshakes: a sample moves when in_valid & in_ready at a rising edge; a result
    // moves when out_valid & out_ready at a rising edge, and is held stable until then.

    localparam int PTR_W = $clog2(DEPTH);
    localparam int REM_W = $clog2(DEPTH) + 1;
    localparam int BIT_W = $clog2(ACC_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] win_q [DEPTH];
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [ACC_W-1:0] quot_q, quot_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] avg_q, avg_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             full_now;
    logic [WIDTH-1:0] oldest;
    logic [REM_W-1:0] rem_shift;
    logic             qbit;

    assign in_ready   = (state_q == IDLE) && !clear;
    assign accept     = in_valid && in_ready;
    assign full_now   = (fill_q == CNT_W'(DEPTH));
    // Until the window is full the slot being overwritten holds no real sample.
    assign oldest     = full_now ? win_q[wr_ptr_q] : '0;
    assign rem_shift  = {rem_q[REM_W-2:0], quot_q[ACC_W-1]};
    assign qbit       = (rem_shift >= REM_W'(DEPTH));

    assign out_valid  = (state_q == HOLD);
    assign avg        = avg_q;
    assign overflow   = ovf_q;
    assign fill_count = fill_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        bit_d      = bit_q;
        ovf_pend_d = ovf_pend_q;
        avg_d      = avg_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sum_d    = sum_q + ACC_W'(in_data) - ACC_W'(oldest);
                    wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                    if (!full_now) fill_d = fill_q + 1'b1;
                    if (full_now || (fill_q == CNT_W'(DEPTH - 1))) begin
                        state_d    = DIVIDE;
                        quot_d     = sum_d;
                        rem_d      = '0;
                        bit_d      = '0;
                        ovf_pend_d = (LEGACY_OVF != 0) && (sum_d[ACC_W-1:WIDTH] != '0);
                    end
                end
            end
            DIVIDE: begin
                // Dividend bits shift out of quot_q's top while quotient bits shift in at the bottom.
                rem_d  = qbit ? (rem_shift - REM_W'(DEPTH)) : rem_shift;
                quot_d = {quot_q[ACC_W-2:0], qbit};
                bit_d  = bit_q + 1'b1;
                if (bit_q == BIT_W'(ACC_W - 1)) begin
                    state_d = HOLD;
                    avg_d   = ovf_pend_q ? '0 : quot_d[WIDTH-1:0];
                    ovf_d   = ovf_pend_q;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d  = IDLE;
            sum_d    = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
            avg_d    = '0;
            ovf_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            bit_q      <= '0;
            ovf_pend_q <= 1'b0;
            avg_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            bit_q      <= bit_d;
            ovf_pend_q <= ovf_pend_d;
            avg_q      <= avg_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
        end else if (accept) begin
            win_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
